// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// first-word-fall-through byte FIFO behind a valid/ready handshake.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_reg, state_next;

    logic             rxd_meta_reg;
    logic             rxd_s_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             frame_err_reg;
    logic             overrun_reg;

    logic [7:0]       mem_reg [FIFO_DEPTH];
    logic [ADDR_W:0]  wr_ptr_reg;
    logic [ADDR_W:0]  rd_ptr_reg;

    logic half_hit;
    logic bit_hit;
    logic cnt_clr;
    logic idx_clr;
    logic shift_en;
    logic byte_done;
    logic stop_err;

    logic fifo_full;
    logic fifo_pop;
    logic fifo_write;

    assign half_hit = (cnt_reg == HALF_M1);
    assign bit_hit  = (cnt_reg == FULL_M1);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_s_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxd_s_reg    <= rxd_meta_reg;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!rxd_s_reg) state_next = S_START;
            S_START: if (half_hit) state_next = rxd_s_reg ? S_IDLE : S_DATA;
            S_DATA:  if (bit_hit && bit_idx_reg == 3'd7) state_next = S_STOP;
            S_STOP:  if (bit_hit) state_next = rxd_s_reg ? S_IDLE : S_BREAK;
            S_BREAK: if (rxd_s_reg) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        case (state_reg)
            S_IDLE:  cnt_clr = 1'b1;
            S_START: begin
                idx_clr = 1'b1;
                cnt_clr = half_hit;
            end
            S_DATA: begin
                shift_en = bit_hit;
                cnt_clr  = bit_hit;
            end
            S_STOP: begin
                cnt_clr   = bit_hit;
                byte_done = bit_hit & rxd_s_reg;
                stop_err  = bit_hit & ~rxd_s_reg;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing and LSB-first byte assembly.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            cnt_reg <= cnt_clr ? '0 : cnt_reg + 1'b1;
            if (idx_clr) begin
                bit_idx_reg <= '0;
            end else if (shift_en) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rxd_s_reg, shift_reg[7:1]};
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                        (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign rx_valid   = (wr_ptr_reg != rd_ptr_reg);
    assign fifo_pop   = rx_valid & rx_ready;
    assign fifo_write = byte_done & (~fifo_full | fifo_pop);
    assign rx_data    = mem_reg[rd_ptr_reg[ADDR_W-1:0]];

    always_ff @(posedge sys_clk) begin
        if (fifo_write) begin
            mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (fifo_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            frame_err_reg <= stop_err;
            overrun_reg   <= byte_done & fifo_full & ~fifo_pop;
        end
    end

    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked every
// cycle against a cycle-count based reference of the receiver and its FIFO.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic       clk;
    logic       sys_rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int fe_count    = 0;
    int ov_count    = 0;
    bit rand_ready  = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: line sampled through a 2-cycle delay; a frame is timed purely
    // from t0 (first low sample while idle) using the nominal sample offsets.
    logic       m_sync1, m_sync2;
    int         m_mode;       // 0 idle, 1 in frame, 2 waiting for line high
    int         m_cyc;
    int         m_t0;
    logic [7:0] m_bits;
    logic [7:0] m_q[$];
    logic       exp_fe, exp_ov;

    initial begin
        m_sync1 = 1'b1; m_sync2 = 1'b1; m_mode = 0; m_cyc = 0; m_t0 = 0;
        m_bits = '0; exp_fe = 1'b0; exp_ov = 1'b0;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (sys_rst) begin
                m_sync1 = 1'b1; m_sync2 = 1'b1; m_mode = 0;
                m_q.delete(); exp_fe = 1'b0; exp_ov = 1'b0;
            end else begin
                logic s, push, pop, full;
                int e, k;
                s = m_sync2;
                m_sync2 = m_sync1;
                m_sync1 = uart_rxd;
                exp_fe = 1'b0; exp_ov = 1'b0; push = 1'b0;
                if (m_mode == 0) begin
                    if (!s) begin
                        m_mode = 1;
                        m_t0 = m_cyc;
                    end
                end else if (m_mode == 1) begin
                    e = m_cyc - m_t0;
                    if (e == HALF) begin
                        if (s) m_mode = 0;
                    end else if (e > HALF && (e - HALF) % CPB == 0) begin
                        k = (e - HALF) / CPB;
                        if (k <= 8) begin
                            m_bits[k-1] = s;
                        end else begin
                            if (s) begin
                                push = 1'b1;
                                m_mode = 0;
                            end else begin
                                exp_fe = 1'b1;
                                m_mode = 2;
                            end
                        end
                    end
                end else begin
                    if (s) m_mode = 0;
                end
                full = (m_q.size() == DEPTH);
                pop = (m_q.size() > 0) && rx_ready;
                if (pop) begin
                    $display("pop byte 0x%02h at t=%0t", m_q[0], $time);
                    void'(m_q.pop_front());
                end
                if (push) begin
                    if (full && !pop) exp_ov = 1'b1;
                    else m_q.push_back(m_bits);
                end
            end
        end
    end

    // Per-cycle comparison against the reference.
    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_q.size() > 0});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
            chk("overrun", {31'd0, overrun}, {31'd0, exp_ov});
            if (m_q.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, m_q[0]});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) fe_count++;
            if (overrun === 1'b1) ov_count++;
        end
    end

    task automatic tick(input logic v);
        uart_rxd = v;
        if (rand_ready) rx_ready = ($urandom_range(0, 2) == 0);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int c = 0; c < CPB; c++) tick(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) tick(b[i]);
        for (int c = 0; c < CPB; c++) tick(stop);
    endtask

    task automatic pop_check(input logic [7:0] exp);
        chk("pop_valid", {31'd0, rx_valid}, 32'd1);
        chk("pop_data", {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int base, lat;
        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        sys_rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with latency from the falling edge to rx_valid.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (rx_valid !== 1'b1 && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk("a5_latency", lat, 32'd155);
        pop_check(8'hA5);
        chk("a5_empty_after_pop", {31'd0, rx_valid}, 32'd0);

        // Glitch shorter than half a bit.
        base = fe_count;
        for (int c = 0; c < 4; c++) tick(1'b0);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 30; c++) tick(1'b1);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_no_fe", fe_count - base, 32'd0);

        // Framing error followed by a held-low line.
        base = fe_count;
        send_frame(8'h3C, 1'b0);
        for (int c = 0; c < 40; c++) tick(1'b0);
        chk("break_busy", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 10; c++) tick(1'b1);
        chk("break_released", {31'd0, busy}, 32'd0);
        chk("fe_pulses", fe_count - base, 32'd1);
        chk("fe_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h55, 1'b1);
        pop_check(8'h55);

        // Overrun on the fifth back-to-back byte.
        base = ov_count;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 1) chk("ovr_valid_first", {31'd0, rx_valid}, 32'd1);
        end
        chk("ovr_pulses", ov_count - base, 32'd1);
        for (int i = 1; i <= 4; i++) pop_check(8'(i));
        chk("ovr_drained", {31'd0, rx_valid}, 32'd0);

        // Full FIFO with a pop on the stop-sample edge.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        base = ov_count;
        fork
            send_frame(8'h66, 1'b1);
            begin
                repeat (154) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        chk("fullpop_no_ovr", ov_count - base, 32'd0);
        pop_check(8'h02);
        pop_check(8'h03);
        pop_check(8'h04);
        pop_check(8'h66);
        chk("fullpop_drained", {31'd0, rx_valid}, 32'd0);

        // Reset during data bit 3.
        base = fe_count;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (CPB * 4 + HALF) @(negedge clk);
                sys_rst = 1'b1;
                @(negedge clk);
                sys_rst = 1'b0;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_valid", {31'd0, rx_valid}, 32'd0);
            end
        join
        repeat (10) @(negedge clk);
        chk("rst_no_byte", {31'd0, rx_valid}, 32'd0);
        chk("rst_no_fe", fe_count - base, 32'd0);
        send_frame(8'h81, 1'b1);
        pop_check(8'h81);

        // Randomized traffic with a randomly stalling consumer.
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 20);
            for (int c = 0; c < gap; c++) tick(1'b1);
            if ($urandom_range(0, 7) == 0) begin
                gap = $urandom_range(1, HALF - 2);
                for (int c = 0; c < gap; c++) tick(1'b0);
                for (int c = 0; c < CPB; c++) tick(1'b1);
            end
            if ($urandom_range(0, 9) == 0) begin
                send_frame(8'($urandom_range(0, 255)), 1'b0);
                gap = $urandom_range(0, 20);
                for (int c = 0; c < gap; c++) tick(1'b0);
                for (int c = 0; c < CPB; c++) tick(1'b1);
            end else begin
                send_frame(8'($urandom_range(0, 255)), 1'b1);
            end
        end
        rand_ready = 0;
        uart_rxd = 1'b1;
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        chk("final_drained", {31'd0, rx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
